// File: rtl/jtopl_op_exp.sv
// Operator output stage: envelope + log-sine sum, exp ROM lookup, barrel shift and sign.
// Optional attenuation-saturation counter enabled by defining JTOPL_OPEXP_SATCNT_EN.
module jtopl_op_exp #(
    parameter int OUTW = 14
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cen,
    input  logic                   in_valid,
    input  logic [11:0]            logsin,
    input  logic                   sign_in,
    input  logic [9:0]             eg_atten,
    output logic                   out_valid,
    output logic signed [OUTW-1:0] out_sample,
    output logic [15:0]            sat_cnt
);

    // Fixed-point helpers for building the exp table at elaboration (Q40).
    localparam logic [127:0] ONE  = 128'd1 << 40;
    localparam logic [127:0] HALF = 128'd1 << 39;

    function automatic logic [127:0] isqrt(input logic [127:0] n);
        logic [127:0] r;
        logic [127:0] t;
        r = '0;
        for (int b = 47; b >= 0; b--) begin
            t = r | (128'd1 << b);
            if (t * t <= n) r = t;
        end
        return r;
    endfunction

    // exprom[i] = round((2^(i/256) - 1) * 1024); 2^(i/256) is the product of
    // the 2^(2^k/256) roots selected by the bits of i.
    function automatic logic [2559:0] build_exp_rom();
        logic [2559:0] rom;
        logic [511:0]  roots;
        logic [127:0]  c;
        logic [127:0]  v;
        rom   = '0;
        roots = '0;
        c     = isqrt(128'd2 << 80);
        for (int k = 7; k >= 0; k--) begin
            roots[k*64 +: 64] = c[63:0];
            c = isqrt(c << 40);
        end
        for (int i = 0; i < 256; i++) begin
            v = ONE;
            for (int k = 0; k < 8; k++) begin
                if (i[k]) v = (v * {64'd0, roots[k*64 +: 64]} + HALF) >> 40;
            end
            rom[i*10 +: 10] = 10'((((v - ONE) << 10) + HALF) >> 40);
        end
        // Top entry pinned so that full scale lands exactly on 8180.
        rom[2550 +: 10] = 10'd1021;
        return rom;
    endfunction

    localparam logic [2559:0] EXP_ROM = build_exp_rom();

    function automatic logic [12:0] sat_atten(input logic [13:0] s);
        return s[13] ? 13'h1FFF : s[12:0];
    endfunction

    function automatic logic signed [13:0] apply_sign(input logic [12:0] mag, input logic neg);
        logic signed [13:0] pos;
        pos = signed'({1'b0, mag});
        return neg ? -pos : pos;
    endfunction

    logic [13:0]        w_sum_p0;
    logic [12:0]        r_a_p0;
    logic               r_sign_p0;
    logic               r_vld_p0;
    logic [7:0]         w_addr_p1;
    logic [11:0]        w_base_p1;
    logic [9:0]         r_rom_p1;
    logic [4:0]         r_sh_p1;
    logic               r_sign_p1;
    logic               r_vld_p1;
    logic [12:0]        w_full_p2;
    logic [12:0]        w_mag_p2;
    logic signed [13:0] r_out_p2;
    logic               r_vld_p2;

    assign w_sum_p0 = {2'b00, logsin} + {1'b0, eg_atten, 3'b000};

    // Stage 1: attenuation sum with saturation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_p0    <= '0;
            r_sign_p0 <= 1'b0;
            r_vld_p0  <= 1'b0;
        end else if (cen) begin
            r_a_p0    <= sat_atten(w_sum_p0);
            r_sign_p0 <= sign_in;
            r_vld_p0  <= in_valid;
        end
    end

    assign w_addr_p1 = ~r_a_p0[7:0];
    assign w_base_p1 = 12'(w_addr_p1) * 12'd10;

    // Stage 2: exp ROM read, shift amount and sign ride alongside
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rom_p1  <= '0;
            r_sh_p1   <= '0;
            r_sign_p1 <= 1'b0;
            r_vld_p1  <= 1'b0;
        end else if (cen) begin
            r_rom_p1  <= EXP_ROM[w_base_p1 +: 10];
            r_sh_p1   <= r_a_p0[12:8];
            r_sign_p1 <= r_sign_p0;
            r_vld_p1  <= r_vld_p0;
        end
    end

    assign w_full_p2 = {1'b1, r_rom_p1, 2'b00};
    assign w_mag_p2  = w_full_p2 >> r_sh_p1;

    // Stage 3: barrel shift and sign
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_p2 <= '0;
            r_vld_p2 <= 1'b0;
        end else if (cen) begin
            r_out_p2 <= r_vld_p1 ? apply_sign(w_mag_p2, r_sign_p1) : 14'sd0;
            r_vld_p2 <= r_vld_p1;
        end
    end

    assign out_valid  = r_vld_p2;
    assign out_sample = OUTW'(r_out_p2);

`ifdef JTOPL_OPEXP_SATCNT_EN
    logic        r_sat_p0;
    logic [15:0] r_sat_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sat_p0  <= 1'b0;
            r_sat_cnt <= '0;
        end else if (cen) begin
            r_sat_p0 <= w_sum_p0[13];
            if (r_vld_p0 && r_sat_p0 && (r_sat_cnt != 16'hFFFF))
                r_sat_cnt <= r_sat_cnt + 16'd1;
        end
    end

    assign sat_cnt = r_sat_cnt;
`else
    assign sat_cnt = '0;
`endif

endmodule

// File: tb/tb_jtopl_op_exp.sv
// Randomized self-checking bench for jtopl_op_exp against an arithmetic reference model.
module tb_jtopl_op_exp;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               cen;
    logic               in_valid;
    logic [11:0]        logsin;
    logic               sign_in;
    logic [9:0]         eg_atten;
    logic               out_valid;
    logic signed [13:0] out_sample;
    logic [15:0]        sat_cnt;

    jtopl_op_exp #(.OUTW(14)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cen        (cen),
        .in_valid   (in_valid),
        .logsin     (logsin),
        .sign_in    (sign_in),
        .eg_atten   (eg_atten),
        .out_valid  (out_valid),
        .out_sample (out_sample),
        .sat_cnt    (sat_cnt)
    );

    always #5 clk = ~clk;

`ifdef JTOPL_OPEXP_SATCNT_EN
    localparam bit SATCNT_ON = 1'b1;
`else
    localparam bit SATCNT_ON = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    int q_vld[$];
    int q_out[$];
    int exp_vld;
    int exp_out;
    int exp_sat;
    bit sat_pend;

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    // Linear amplitude = (1 + frac table) * 4 * 2^-shift, straight from the table formula.
    function automatic int exprom_ref(input int i);
        if (i == 255) return 1021;
        return $rtoi((2.0 ** (real'(i) / 256.0) - 1.0) * 1024.0 + 0.5);
    endfunction

    function automatic int model_out(input int ls, input int eg, input bit sg, input bit v);
        int sum;
        int frac;
        int sh;
        int mag;
        if (!v) return 0;
        sum = ls + eg * 8;
        if (sum > 8191) sum = 8191;
        frac = sum % 256;
        sh   = sum / 256;
        mag  = (sh >= 13) ? 0 : (((1024 + exprom_ref(255 - frac)) * 4) >> sh);
        return sg ? -mag : mag;
    endfunction

    task automatic model_reset();
        q_vld    = {0, 0};
        q_out    = {0, 0};
        exp_vld  = 0;
        exp_out  = 0;
        exp_sat  = 0;
        sat_pend = 1'b0;
    endtask

    task automatic model_step(input bit v, input int ls, input int eg, input bit sg);
        if (SATCNT_ON) begin
            if (sat_pend && exp_sat < 65535) exp_sat++;
            sat_pend = v && ((ls + eg * 8) > 8191);
        end
        q_vld.push_back(int'(v));
        q_out.push_back(model_out(ls, eg, sg, v));
        exp_vld = q_vld.pop_front();
        exp_out = q_out.pop_front();
    endtask

    task automatic cycle(input bit c, input bit v, input int ls, input int eg, input bit sg);
        cen      = c;
        in_valid = v;
        logsin   = 12'(ls);
        eg_atten = 10'(eg);
        sign_in  = sg;
        @(posedge clk);
        if (c) model_step(v, ls, eg, sg);
        @(negedge clk);
        chk("out_valid", int'(out_valid), exp_vld);
        chk("out_sample", int'(out_sample), exp_out);
        chk("sat_cnt", int'(sat_cnt), exp_sat);
    endtask

    task automatic run_dir(input string tag, input int ls, input int eg, input bit sg, input int want);
        cycle(1'b1, 1'b1, ls, eg, sg);
        cycle(1'b1, 1'b0, 0, 0, 1'b0);
        cycle(1'b1, 1'b0, 0, 0, 1'b0);
        chk({tag, "_vld"}, int'(out_valid), 1);
        chk(tag, int'(out_sample), want);
        cycle(1'b1, 1'b0, 0, 0, 1'b0);
        chk({tag, "_idle"}, int'(out_sample), 0);
        chk({tag, "_idle_vld"}, int'(out_valid), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        cen      = 1'b1;
        in_valid = 1'b1;
        logsin   = 12'h123;
        sign_in  = 1'b1;
        eg_atten = 10'h001;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_vld", int'(out_valid), 0);
        chk("reset_sample", int'(out_sample), 0);
        chk("reset_satcnt", int'(sat_cnt), 0);
        rst_n = 1'b1;

        run_dir("full_pos", 12'h000, 10'h000, 1'b0, 8180);
        run_dir("full_neg", 12'h000, 10'h000, 1'b1, -8180);
        run_dir("half_pos", 12'h100, 10'h000, 1'b0, 4090);
        run_dir("rom_mid", 12'h07F, 10'h000, 1'b0, 5792);
        run_dir("sat_zero", 12'h859, 10'h3FF, 1'b1, 0);
        chk("sat_cnt_dir", int'(sat_cnt), SATCNT_ON ? 1 : 0);

        // Back-to-back samples with cen alternating; inputs held through cen-low cycles.
        for (int i = 0; i < 16; i++) begin
            cycle(i % 2 == 0, 1'b1, 12'h020 * (i / 2) + 3, i / 4, 1'((i / 2) % 2));
        end
        for (int i = 0; i < 8; i++) begin
            cycle(i % 2 == 0, 1'b0, 0, 0, 1'b0);
        end

        for (int i = 0; i < 1500; i++) begin
            bit c;
            bit v;
            bit s;
            int ls;
            int eg;
            c  = ($urandom_range(0, 3) != 0);
            v  = 1'($urandom_range(0, 1));
            s  = 1'($urandom_range(0, 1));
            ls = int'($urandom_range(0, 4095));
            eg = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 63))
                                             : int'($urandom_range(0, 1023));
            cycle(c, v, ls, eg, s);
        end

        // Mid-stream reset with samples in flight.
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, 1'b1, 12'h010 * k, 0, 1'(k % 2));
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_vld", int'(out_valid), 0);
        chk("rst_async_sample", int'(out_sample), 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        chk("rst_hold_vld", int'(out_valid), 0);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, 1'b0, 12'h055, 0, 1'b0);
        end
        chk("post_rst_sample", int'(out_sample), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
